bcd_conv_sched: RTL and testbench
=================================

Name: bcd_conv_sched

Overview:
- Round-robin scheduler that shares one binary-to-BCD converter (13-bit binary in, 4-digit/16-bit BCD out) between NREQ requesters.
- Arbitrates requests and latches the winner's operand.
- Sequences the converter with a one-cycle start pulse, waits for completion under a watchdog, then returns the result tagged with the requester id.
- Sits between the display/readout clients and the shared converter instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- BIN_W, 13, binary operand width
- BCD_W, 16, BCD result width (4 digits)
- TIMEOUT, 63, max WAIT cycles before a conversion is declared failed (≥ 2)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level
- req_bin  in  NREQ*BIN_W  operands; requester i at [i*BIN_W +: BIN_W]
- gnt  out  NREQ  one-hot owner of the converter
- busy  out  1  high in any state other than IDLE
- conv_start  out  1  one-cycle load/start pulse to the converter
- conv_bin  out  BIN_W  operand to the converter
- conv_done  in  1  converter completion pulse
- conv_bcd  in  BCD_W  converter result, valid with conv_done
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  $clog2(NREQ)  requester the response belongs to
- rsp_bcd  out  BCD_W  result; 0 on error
- rsp_err  out  1  watchdog expired

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, ptr=NREQ-1 so requester 0 has first priority.
  - gnt, busy, conv_start, conv_bin, rsp_valid, rsp_id, rsp_bcd, rsp_err and the timer all 0.
- FSM states: IDLE, START, WAIT, RESP. All outputs are registered or decoded from state only; none depend combinationally on inputs.
- IDLE:
  - req is sampled only here.
  - If req≠0, pick the first set bit searching ptr+1, ptr+2, … modulo NREQ.
  - Latch its id and operand into conv_bin, then go to START.
- START:
  - conv_start=1 for exactly this cycle; gnt one-hot at id.
  - Clear the timer; go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - If conv_done=1: capture conv_bcd into rsp_bcd, set rsp_err=0, go to RESP.
  - Else if timer==TIMEOUT-1: set rsp_bcd=0, rsp_err=1, go to RESP.
  - conv_done in the same cycle as timeout expiry counts as success.
- RESP:
  - rsp_valid=1 for this cycle only; rsp_id, rsp_bcd and rsp_err are valid.
  - ptr<=id; go to IDLE.
- Holding rules:
  - rsp_id, rsp_bcd and rsp_err hold their values after RESP until the next RESP.
  - conv_bin is stable from START through RESP.
  - gnt is asserted from START through RESP and is 0 in IDLE; busy equals (state≠IDLE).
- Latency:
  - req seen in IDLE at cycle n gives conv_start at n+1; WAIT begins at n+2.
  - conv_done sampled at cycle m gives rsp_valid at m+1.
  - Minimum gap between successive conv_start pulses is 4 cycles.
- Requester protocol:
  - Hold req and operand until rsp_valid with a matching rsp_id.
  - Changes to req_bin after the IDLE sample are ignored.
  - A requester that keeps req high is serviced again, but only after all other pending requesters (ptr has moved past it).
- conv_done outside WAIT is ignored.
- Reset mid-operation aborts immediately:
  - No rsp_valid is produced for the aborted job.
  - The converter is not reset by this block; the next conv_start reloads it.
- Widths:
  - Timer width is $clog2(TIMEOUT+1).
  - The round-robin search is combinational over NREQ and must not produce X for unused ids.

Test Plan:
- Single request: req=4'b0001 with operand 4095; converter model asserts conv_done 30 cycles after start with 16'h4095 -> one conv_start pulse, gnt=0001 during the job, rsp_valid with rsp_id=0, rsp_bcd=16'h4095, rsp_err=0.
- All four requesters asserted simultaneously with operands 1, 22, 333, 8191 -> service order 0,1,2,3; results 16'h0001, 16'h0022, 16'h0333, 16'h8191; gnt never has more than one bit set.
- Fairness: req0 held continuously, req2 asserted -> grants alternate 0,2,0,2; no more than one req0 grant between successive req2 grants.
- Watchdog: converter never asserts conv_done -> rsp_valid exactly TIMEOUT+1 cycles after conv_start, with rsp_err=1, rsp_bcd=0; next request then completes normally.
- Reset mid-WAIT: pulse reset_n low for 1 cycle -> all outputs 0 immediately, no response for the aborted job, ptr reset so requester 0 wins next.
- Stray conv_done pulses in IDLE and RESP -> no state change and no extra rsp_valid.

Source files
------------

// File: rtl/bcd_conv_sched.sv
// Round-robin front end that shares a single binary-to-BCD converter between NREQ
// requesters: it arbitrates, issues a one-cycle start, watches for completion and returns the tagged result.
module bcd_conv_sched #(
    parameter int NREQ    = 4,
    parameter int BIN_W   = 13,
    parameter int BCD_W   = 16,
    parameter int TIMEOUT = 63
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*BIN_W-1:0]    req_bin,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     conv_start,
    output logic [BIN_W-1:0]         conv_bin,
    input  logic                     conv_done,
    input  logic [BCD_W-1:0]         conv_bcd,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [BCD_W-1:0]         rsp_bcd,
    output logic                     rsp_err
);

    localparam int IDW = $clog2(NREQ);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMAX     = TW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] PTR_INIT = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_id;
    logic [TW-1:0]      r_timer;
    logic [BIN_W-1:0]   r_conv_bin;
    logic [IDW-1:0]     r_rsp_id;
    logic [BCD_W-1:0]   r_rsp_bcd;
    logic               r_rsp_err;

    logic               w_found;
    logic [IDW-1:0]     w_win;
    logic [IDW-1:0]     w_cand;
    logic [BIN_W-1:0]   w_win_bin;
    logic               w_timeout;

    // Search starts just past the last served id; the modulo keeps candidates inside 0..NREQ-1.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_comb begin
        w_win_bin = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IDW'(i)) begin
                w_win_bin = req_bin[i*BIN_W +: BIN_W];
            end
        end
    end

    assign w_timeout = (r_timer == TMAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (conv_done || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != S_IDLE);
        conv_start = (r_state == S_START);
        rsp_valid  = (r_state == S_RESP);
        gnt        = '0;
        if (r_state != S_IDLE) begin
            gnt[r_id] = 1'b1;
        end
    end

    // Completion wins over an expiring watchdog in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr      <= PTR_INIT;
            r_id       <= '0;
            r_timer    <= '0;
            r_conv_bin <= '0;
            r_rsp_id   <= '0;
            r_rsp_bcd  <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_id       <= w_win;
                        r_conv_bin <= w_win_bin;
                    end
                end
                S_START: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    r_timer <= r_timer + TW'(1);
                    if (conv_done) begin
                        r_rsp_id  <= r_id;
                        r_rsp_bcd <= conv_bcd;
                        r_rsp_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_id  <= r_id;
                        r_rsp_bcd <= '0;
                        r_rsp_err <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_ptr <= r_id;
                end
                default: begin
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign conv_bin = r_conv_bin;
    assign rsp_id   = r_rsp_id;
    assign rsp_bcd  = r_rsp_bcd;
    assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench for bcd_conv_sched: table vectors, hand sequences for the
// multi-cycle corners, and a randomized run against a round-robin reference model.
module tb_bcd_conv_sched;

    localparam int NREQ    = 4;
    localparam int BIN_W   = 13;
    localparam int BCD_W   = 16;
    localparam int TIMEOUT = 63;

    logic                    clk;
    logic                    reset_n;
    logic [NREQ-1:0]         req;
    logic [NREQ*BIN_W-1:0]   req_bin;
    logic [NREQ-1:0]         gnt;
    logic                    busy;
    logic                    conv_start;
    logic [BIN_W-1:0]        conv_bin;
    logic                    conv_done;
    logic [BCD_W-1:0]        conv_bcd;
    logic                    rsp_valid;
    logic [1:0]              rsp_id;
    logic [BCD_W-1:0]        rsp_bcd;
    logic                    rsp_err;

    logic                    model_done;
    logic                    stray_done;
    logic [BCD_W-1:0]        model_bcd;
    int                      conv_delay;

    int n_checks = 0;
    int n_errors = 0;

    assign conv_done = model_done | stray_done;
    assign conv_bcd  = model_bcd;

    bcd_conv_sched #(
        .NREQ(NREQ), .BIN_W(BIN_W), .BCD_W(BCD_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_bin(req_bin),
        .gnt(gnt), .busy(busy), .conv_start(conv_start), .conv_bin(conv_bin),
        .conv_done(conv_done), .conv_bcd(conv_bcd), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_bcd(rsp_bcd), .rsp_err(rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Converter model: answers conv_delay cycles after the start pulse; 0 means never.
    initial begin
        int cd;
        logic [BIN_W-1:0] mop;
        cd = 0;
        mop = '0;
        model_done = 1'b0;
        model_bcd = '0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    model_done = 1'b1;
                    model_bcd = to_bcd(int'(mop));
                end
            end
            if (conv_start && conv_delay > 0) begin
                cd = conv_delay;
                mop = conv_bin;
            end
        end
    end

    initial begin
        @(posedge reset_n);
        forever begin
            @(negedge clk);
            if (reset_n) check("gnt_shape", busy ? $onehot(gnt) : (gnt == '0), 1);
        end
    end

    task automatic do_job(input int exp_id, input logic [BIN_W-1:0] exp_bin,
                          input logic [BCD_W-1:0] exp_bcd, input logic exp_err, input int exp_lat);
        bit seen;
        int lat;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (conv_start) begin
                seen = 1;
                break;
            end
        end
        check("start_seen", seen, 1);
        if (!seen) return;
        check("gnt_at_start", gnt, 64'(1) << exp_id);
        check("conv_bin_at_start", conv_bin, exp_bin);
        lat = 0;
        seen = 0;
        while (lat < TIMEOUT + 10) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check("start_one_cycle", conv_start, 0);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        check("rsp_seen", seen, 1);
        if (!seen) return;
        check("rsp_id", rsp_id, exp_id);
        check("rsp_bcd", rsp_bcd, exp_bcd);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_latency", lat, exp_lat);
        check("conv_bin_hold", conv_bin, exp_bin);
        check("gnt_at_resp", gnt, 64'(1) << exp_id);
    endtask

    typedef struct {
        logic [NREQ-1:0]       rq;
        logic [NREQ*BIN_W-1:0] ops;
        int                    delay;
        int                    exp_id;
        logic [BCD_W-1:0]      exp_bcd;
        logic                  exp_err;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [BIN_W-1:0] rops[NREQ];
        logic [NREQ-1:0]  rq;
        logic [NREQ-1:0]  nb;
        logic [BCD_W-1:0] exp4[4];
        int mptr;
        int id;
        int d;
        int cnt;
        bit seen;

        tbl[0] = '{4'b0001, {13'd0, 13'd0, 13'd0, 13'd4095}, 30, 0, 16'h4095, 1'b0};
        tbl[1] = '{4'b1001, {13'd8191, 13'd0, 13'd0, 13'd7}, 1, 3, 16'h8191, 1'b0};
        tbl[2] = '{4'b1001, {13'd5, 13'd0, 13'd0, 13'd10}, TIMEOUT, 0, 16'h0010, 1'b0};
        tbl[3] = '{4'b0110, {13'd0, 13'd9, 13'd0, 13'd0}, 0, 1, 16'h0000, 1'b1};
        tbl[4] = '{4'b0110, {13'd0, 13'd1234, 13'd100, 13'd0}, 2, 2, 16'h1234, 1'b0};
        tbl[5] = '{4'b0100, {13'd0, 13'd8190, 13'd0, 13'd0}, 3, 2, 16'h8190, 1'b0};
        exp4[0] = 16'h0001; exp4[1] = 16'h0022; exp4[2] = 16'h0333; exp4[3] = 16'h8191;

        reset_n = 1'b1;
        req = '0;
        req_bin = '0;
        conv_delay = 0;
        stray_done = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("reset_gnt", gnt, 0);
        check("reset_busy", busy, 0);
        check("reset_conv_start", conv_start, 0);
        check("reset_conv_bin", conv_bin, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_bcd", rsp_bcd, 0);
        check("reset_rsp_err", rsp_err, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // All four at once: served 0,1,2,3 from the reset pointer.
        req_bin = {13'd8191, 13'd333, 13'd22, 13'd1};
        conv_delay = 4;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            do_job(k, req_bin[k*BIN_W +: BIN_W], exp4[k], 1'b0, 5);
            req[k] = 1'b0;
        end

        // Fairness: both held, grants must alternate 0,2,0,2.
        req_bin = {13'd0, 13'd222, 13'd0, 13'd111};
        conv_delay = 3;
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            id = (k % 2 == 0) ? 0 : 2;
            do_job(id, req_bin[id*BIN_W +: BIN_W], to_bcd(id == 0 ? 111 : 222), 1'b0, 4);
        end
        req = '0;

        for (int i = 0; i < 6; i++) begin
            req_bin = tbl[i].ops;
            conv_delay = tbl[i].delay;
            req = tbl[i].rq;
            do_job(tbl[i].exp_id, tbl[i].ops[tbl[i].exp_id*BIN_W +: BIN_W], tbl[i].exp_bcd,
                   tbl[i].exp_err, (tbl[i].delay == 0) ? TIMEOUT + 1 : tbl[i].delay + 1);
            req = '0;
            @(negedge clk);
            check("rsp_valid_one_cycle", rsp_valid, 0);
            check("idle_after_resp", busy, 0);
            check("rsp_id_hold", rsp_id, tbl[i].exp_id);
            check("rsp_bcd_hold", rsp_bcd, tbl[i].exp_bcd);
        end

        // Stray completion pulses in RESP and then in IDLE.
        req_bin = {13'd0, 13'd0, 13'd55, 13'd0};
        conv_delay = 7;
        req = 4'b0010;
        do_job(1, 13'd55, 16'h0055, 1'b0, 8);
        req = '0;
        stray_done = 1'b1;
        @(negedge clk);
        check("stray_resp_busy", busy, 0);
        check("stray_resp_valid", rsp_valid, 0);
        @(negedge clk);
        stray_done = 1'b0;
        cnt = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (busy || rsp_valid) cnt++;
        end
        check("stray_idle_no_activity", cnt, 0);
        check("stray_rsp_bcd_hold", rsp_bcd, 16'h0055);

        // Reset in the middle of WAIT aborts the job and restores the pointer.
        req_bin = {13'd0, 13'd0, 13'd77, 13'd0};
        conv_delay = 0;
        req = 4'b0010;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (conv_start) begin
                seen = 1;
                break;
            end
        end
        check("abort_start_seen", seen, 1);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        req = '0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_gnt", gnt, 0);
        check("abort_conv_bin", conv_bin, 0);
        check("abort_rsp_id", rsp_id, 0);
        check("abort_rsp_bcd", rsp_bcd, 0);
        check("abort_rsp_err", rsp_err, 0);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rsp_valid || busy) cnt++;
        end
        check("abort_no_rsp", cnt, 0);
        req_bin = {13'd6, 13'd0, 13'd5, 13'd0};
        conv_delay = 2;
        req = 4'b1010;
        do_job(1, 13'd5, 16'h0005, 1'b0, 3);
        req = '0;

        // Randomized run against the round-robin reference model.
        mptr = 1;
        rq = '0;
        for (int i = 0; i < NREQ; i++) rops[i] = '0;
        for (int j = 0; j < 30; j++) begin
            if (rq == '0) begin
                rq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                for (int i = 0; i < NREQ; i++) if (rq[i]) rops[i] = BIN_W'($urandom_range(0, 8191));
            end
            d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT);
            conv_delay = d;
            for (int i = 0; i < NREQ; i++) req_bin[i*BIN_W +: BIN_W] = rops[i];
            req = rq;
            id = rr_pick(rq, mptr);
            do_job(id, rops[id], (d == 0) ? 16'h0000 : to_bcd(int'(rops[id])), d == 0,
                   (d == 0) ? TIMEOUT + 1 : d + 1);
            mptr = id;
            if ($urandom_range(0, 2) != 0) rq[id] = 1'b0;
            nb = NREQ'($urandom_range(0, (1 << NREQ) - 1)) & ~rq;
            for (int i = 0; i < NREQ; i++) if (nb[i]) rops[i] = BIN_W'($urandom_range(0, 8191));
            rq = rq | nb;
            for (int i = 0; i < NREQ; i++) req_bin[i*BIN_W +: BIN_W] = rops[i];
            req = rq;
        end
        req = '0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
